// File: rtl/can_acceptance_filter.sv
// CAN standard-identifier acceptance filter.
// Assembles the 11-bit identifier and the RTR bit from the destuffed receive
// bit stream, then compares the identifier against a mask/code pair.
// The mask/code pair is captured at start of frame.
// The block issues one accept or reject pulse per completed identifier and
// keeps saturating statistics of both outcomes.
module can_acceptance_filter #(
    parameter int ID_W  = 11,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sof,
    input  logic             bit_valid,
    input  logic             rx_bit,
    input  logic             frame_end,
    input  logic [ID_W-1:0]  mask_param,
    input  logic [ID_W-1:0]  code_param,
    output logic [ID_W-1:0]  rx_id,
    output logic             rx_rtr,
    output logic             id_valid,
    output logic             match,
    output logic             accept,
    output logic             reject,
    output logic             busy,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] reject_cnt
);

    localparam int BC_W = $clog2(ID_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        ID,
        RTR,
        WAIT_EOF
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [BC_W-1:0]  bit_cnt;
    logic [ID_W-1:0]  shift_reg;
    logic [ID_W-1:0]  mask_shadow;
    logic [ID_W-1:0]  code_shadow;
    logic             last_id_bit;
    logic             decide;
    logic             id_hit;

    // The final identifier bit is the one that arrives while the counter shows ID_W-1.
    assign last_id_bit = (bit_cnt == BC_W'(ID_W - 1));
    // A frame_end in the same cycle as the RTR bit aborts the frame, so no decision is made.
    assign decide      = (state == RTR) && bit_valid && !sof && !frame_end;
    assign id_hit      = ((shift_reg ^ code_shadow) & mask_shadow) == '0;
    assign busy        = (state != IDLE);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. sof restarts the frame from any state and takes priority over frame_end.
    // NOTE: state_next gets its default first, so always_comb cannot infer a latch.
    always_comb begin
        state_next = state;
        if (sof) begin
            state_next = ID;
        end else begin
            unique case (state)
                IDLE:     state_next = IDLE;
                ID: begin
                    if (frame_end)                      state_next = IDLE;
                    else if (bit_valid && last_id_bit)  state_next = RTR;
                end
                RTR: begin
                    if (frame_end)      state_next = IDLE;
                    else if (bit_valid) state_next = WAIT_EOF;
                end
                WAIT_EOF: begin
                    if (frame_end) state_next = IDLE;
                end
                default:  state_next = IDLE;
            endcase
        end
    end

    // Datapath: capture the config, shift in identifier bits, and register the
    // decision and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            mask_shadow <= '0;
            code_shadow <= '0;
            rx_id       <= '0;
            rx_rtr      <= 1'b0;
            match       <= 1'b0;
            id_valid    <= 1'b0;
            accept      <= 1'b0;
            reject      <= 1'b0;
            accept_cnt  <= '0;
            reject_cnt  <= '0;
        end else begin
            id_valid <= 1'b0;
            accept   <= 1'b0;
            reject   <= 1'b0;
            if (sof) begin
                // The bit that arrives with sof is the SOF bit itself, so it is not shifted in.
                mask_shadow <= mask_param;
                code_shadow <= code_param;
                bit_cnt     <= '0;
                shift_reg   <= '0;
            end else if (state == ID && bit_valid && !frame_end) begin
                shift_reg <= {shift_reg[ID_W-2:0], rx_bit};
                bit_cnt   <= bit_cnt + BC_W'(1);
            end else if (decide) begin
                rx_id    <= shift_reg;
                rx_rtr   <= rx_bit;
                match    <= id_hit;
                id_valid <= 1'b1;
                accept   <= id_hit;
                reject   <= !id_hit;
                if (id_hit && accept_cnt != '1) begin
                    accept_cnt <= accept_cnt + CNT_W'(1);
                end
                if (!id_hit && reject_cnt != '1) begin
                    reject_cnt <= reject_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_can_acceptance_filter.sv
// Self-checking bench for can_acceptance_filter.
// A frame-level model counts the received bits since the last sof and decides
// after the 12th bit. Every output is compared with the model on each falling
// edge, and literal expectations pin down the directed scenarios.
module tb_can_acceptance_filter;

    localparam int ID_W  = 11;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sof = 1'b0;
    logic             bit_valid = 1'b0;
    logic             rx_bit = 1'b0;
    logic             frame_end = 1'b0;
    logic [ID_W-1:0]  mask_param = '0;
    logic [ID_W-1:0]  code_param = '0;
    logic [ID_W-1:0]  rx_id;
    logic             rx_rtr;
    logic             id_valid;
    logic             match;
    logic             accept;
    logic             reject;
    logic             busy;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] reject_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: bits seen since sof (-1 = no frame in progress).
    int nbits = -1;
    int id_acc = 0;
    int m_mask = 0, m_code = 0;
    int e_id = 0, e_rtr = 0, e_match = 0, e_valid = 0, e_acc = 0, e_rej = 0;
    int e_acnt = 0, e_rcnt = 0, e_busy = 0;
    int acc_pulses = 0, rej_pulses = 0;
    int base_acc, base_rej;

    can_acceptance_filter #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sof        (sof),
        .bit_valid  (bit_valid),
        .rx_bit     (rx_bit),
        .frame_end  (frame_end),
        .mask_param (mask_param),
        .code_param (code_param),
        .rx_id      (rx_id),
        .rx_rtr     (rx_rtr),
        .id_valid   (id_valid),
        .match      (match),
        .accept     (accept),
        .reject     (reject),
        .busy       (busy),
        .accept_cnt (accept_cnt),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: count bits after sof and decide on the 12th.
    always @(posedge clk) begin
        e_valid = 0;
        e_acc   = 0;
        e_rej   = 0;
        if (reset) begin
            nbits = -1; id_acc = 0; m_mask = 0; m_code = 0;
            e_id = 0; e_rtr = 0; e_match = 0; e_acnt = 0; e_rcnt = 0;
        end else if (sof) begin
            m_mask = int'(mask_param);
            m_code = int'(code_param);
            nbits  = 0;
            id_acc = 0;
        end else if (frame_end) begin
            nbits = -1;
        end else if (bit_valid && nbits >= 0 && nbits <= ID_W) begin
            if (nbits < ID_W) begin
                id_acc = id_acc * 2 + int'(rx_bit);
            end else begin
                e_id    = id_acc;
                e_rtr   = int'(rx_bit);
                e_match = (((id_acc ^ m_code) & m_mask) == 0) ? 1 : 0;
                e_valid = 1;
                e_acc   = e_match;
                e_rej   = 1 - e_match;
                if (e_match == 1) e_acnt = (e_acnt < CMAX) ? e_acnt + 1 : CMAX;
                else              e_rcnt = (e_rcnt < CMAX) ? e_rcnt + 1 : CMAX;
            end
            nbits++;
        end
        e_busy = (nbits >= 0) ? 1 : 0;
    end

    // Compare every output with the model away from the active edge.
    always @(negedge clk) begin
        if (accept) acc_pulses++;
        if (reject) rej_pulses++;
        if (chk_en) begin
            check("rx_id",      int'(rx_id),      e_id);
            check("rx_rtr",     int'(rx_rtr),     e_rtr);
            check("match",      int'(match),      e_match);
            check("id_valid",   int'(id_valid),   e_valid);
            check("accept",     int'(accept),     e_acc);
            check("reject",     int'(reject),     e_rej);
            check("busy",       int'(busy),       e_busy);
            check("accept_cnt", int'(accept_cnt), e_acnt);
            check("reject_cnt", int'(reject_cnt), e_rcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; sof = 1'b0; bit_valid = 1'b0; frame_end = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_bits(input logic [ID_W-1:0] id, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            rx_bit = id[ID_W-1-i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // Full frame: identifier MSB first, RTR, two ignored data bits, then frame_end.
    // code_after is applied right after sof. gap_at inserts one idle cycle before that bit index.
    task automatic send_frame(input logic [ID_W-1:0] id, input logic rtr,
                              input logic [ID_W-1:0] mask, input logic [ID_W-1:0] code,
                              input logic [ID_W-1:0] code_after, input int gap_at);
        mask_param = mask;
        code_param = code;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        code_param = code_after;
        for (int i = ID_W - 1; i >= 0; i--) begin
            if (i == gap_at) begin
                bit_valid = 1'b0;
                tick();
            end
            bit_valid = 1'b1;
            rx_bit = id[i];
            tick();
        end
        rx_bit = rtr;
        tick();
        rx_bit = 1'b1;
        tick();
        rx_bit = 1'b0;
        tick();
        bit_valid = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset busy",   int'(busy), 0);
        check("reset rx_id",  int'(rx_id), 0);
        check("reset acnt",   int'(accept_cnt), 0);
        check("reset rcnt",   int'(reject_cnt), 0);

        // Exact match.
        base_acc = acc_pulses;
        send_frame(11'h2AA, 1'b0, 11'h7FF, 11'h2AA, 11'h2AA, -1);
        check("exact rx_id",  int'(rx_id), 'h2AA);
        check("exact match",  int'(match), 1);
        check("exact acnt",   int'(accept_cnt), 1);
        check("exact pulses", acc_pulses - base_acc, 1);

        // Masked don't-care bits, with one idle gap inside the identifier.
        do_reset();
        base_acc = acc_pulses; base_rej = rej_pulses;
        send_frame(11'h5FF, 1'b0, 11'h700, 11'h500, 11'h500, 4);
        send_frame(11'h4FF, 1'b0, 11'h700, 11'h500, 11'h500, -1);
        check("mask acnt",    int'(accept_cnt), 1);
        check("mask rcnt",    int'(reject_cnt), 1);
        check("mask match",   int'(match), 0);
        check("mask rx_id",   int'(rx_id), 'h4FF);
        check("mask acc pul", acc_pulses - base_acc, 1);
        check("mask rej pul", rej_pulses - base_rej, 1);

        // Abort and restart: no decision for partial frames.
        do_reset();
        base_acc = acc_pulses; base_rej = rej_pulses;
        sof = 1'b1; tick(); sof = 1'b0;
        send_bits(11'h7FF, 6);
        frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
        check("abort busy",   int'(busy), 0);
        sof = 1'b1; tick(); sof = 1'b0;
        send_bits(11'h555, 4);
        // sof with frame_end and bit_valid in the same cycle: sof wins and the bit is dropped.
        sof = 1'b1; frame_end = 1'b1; bit_valid = 1'b1; rx_bit = 1'b1;
        tick();
        sof = 1'b0; frame_end = 1'b0; bit_valid = 1'b0;
        check("restart busy", int'(busy), 1);
        send_bits(11'h0F0, 3);
        send_frame(11'h123, 1'b1, 11'h000, 11'h7FF, 11'h7FF, -1);
        check("abort acc pul", acc_pulses - base_acc, 1);
        check("abort rej pul", rej_pulses - base_rej, 0);
        check("abort rx_id",   int'(rx_id), 'h123);
        check("abort rx_rtr",  int'(rx_rtr), 1);
        check("abort acnt",    int'(accept_cnt), 1);

        // Config change after sof must not affect the current frame.
        do_reset();
        send_frame(11'h001, 1'b0, 11'h7FF, 11'h001, 11'h002, -1);
        check("cfg match",    int'(match), 1);
        check("cfg acnt",     int'(accept_cnt), 1);

        // Saturation of the reject counter.
        do_reset();
        for (int f = 0; f < 260; f++) begin
            send_frame(11'h000, 1'b0, 11'h7FF, 11'h7FF, 11'h7FF, -1);
        end
        check("sat rcnt",     int'(reject_cnt), 255);
        check("sat acnt",     int'(accept_cnt), 0);

        // Reset in the middle of a frame, then a normal frame.
        send_frame(11'h3C3, 1'b1, 11'h000, 11'h000, 11'h000, -1);
        mask_param = 11'h7FF; code_param = 11'h7FF;
        sof = 1'b1; tick(); sof = 1'b0;
        send_bits(11'h7FF, 8);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst busy",     int'(busy), 0);
        check("rst rx_id",    int'(rx_id), 0);
        check("rst rx_rtr",   int'(rx_rtr), 0);
        check("rst match",    int'(match), 0);
        check("rst acnt",     int'(accept_cnt), 0);
        check("rst rcnt",     int'(reject_cnt), 0);
        send_bits(11'h7FF, 4);
        send_frame(11'h7FF, 1'b0, 11'h7FF, 11'h7FF, 11'h7FF, -1);
        check("post rx_id",   int'(rx_id), 'h7FF);
        check("post acnt",    int'(accept_cnt), 1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
